// File: rtl/gm_scan_if.sv
// ---------------------------------------------------------------------------
// if_wb : 32-bit Wishbone classic bus bundle.
//   cyc, stb  - cycle / strobe (master -> slave)
//   we, sel   - write enable, byte selects (master -> slave)
//   adr       - byte address (master -> slave)
//   dat_o     - write data (master -> slave)
//   dat_i     - read data (slave -> master)
//   ack       - transfer acknowledge (slave -> master)
// ---------------------------------------------------------------------------
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, ack
  );
endinterface

// File: rtl/gm_scan.sv
// ---------------------------------------------------------------------------
// gm_scan : graphics-mode scan-out engine.
// Fetches one framebuffer line per request over a Wishbone classic read
// master into a show-ahead line FIFO, then serialises the FIFO words into
// pixels (MSB first) and maps them to RGB.
//
// Ports
//   clk_i, rst_i       single clock, synchronous active-high reset
//   pix_en             pixel clock enable, one pixel per asserted cycle
//   h_active, v_active display timing from the timing controller
//   fb_base            frame base byte address (word aligned)
//   fg_color, bg_color {r,g,b} palette used when PIX_BITS == 1
//   underflow_clr      clears the sticky underflow flag
//   red, green, blue   registered colour outputs
//   blank_n            registered h_active & v_active
//   underflow          sticky: display starved or line request overrun
//   bus                Wishbone classic read master
// ---------------------------------------------------------------------------
module gm_scan #(
  parameter int BPP      = 8,
  parameter int PIX_BITS = 1,
  parameter int H_PIXELS = 640,
  parameter int FIFO_AW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_en,
  input  logic             h_active,
  input  logic             v_active,
  input  logic [31:0]      fb_base,
  input  logic [3*BPP-1:0] fg_color,
  input  logic [3*BPP-1:0] bg_color,
  input  logic             underflow_clr,
  output logic [BPP-1:0]   red,
  output logic [BPP-1:0]   green,
  output logic [BPP-1:0]   blue,
  output logic             blank_n,
  output logic             underflow,
  if_wb.master             bus
);

  localparam int WPL   = H_PIXELS * PIX_BITS / 32;   // words per line
  localparam int PPW   = 32 / PIX_BITS;              // pixels per word
  localparam int IW    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [4:0]    PB5       = 5'(PIX_BITS);
  localparam logic [4:0]    P_LAST    = 5'(PPW - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WPL - 1);
  localparam logic [31:0]   LINE_STEP = 32'(4 * WPL);

  // Elaboration-time parameter checks.
  if (PIX_BITS != 1 && PIX_BITS != 2 && PIX_BITS != 4 && PIX_BITS != 8) begin : g_bad_pix_bits
    $error("gm_scan: PIX_BITS must be 1, 2, 4 or 8");
  end
  if ((H_PIXELS * PIX_BITS) % 32 != 0) begin : g_bad_line_len
    $error("gm_scan: H_PIXELS*PIX_BITS must be a multiple of 32");
  end
  if (DEPTH < WPL) begin : g_fifo_too_small
    $error("gm_scan: line FIFO shallower than one line");
  end

  // -------------------------------------------------------------------------
  // Timing edge detection
  // -------------------------------------------------------------------------
  logic h_q, v_q, armed_q;
  logic v_fall, h_fall, flush, line_req;

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= 1'b0;
      v_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      h_q <= h_active;
      v_q <= v_active;
      if (v_fall) armed_q <= 1'b1;
    end
  end

  assign v_fall   = v_q & ~v_active;
  assign h_fall   = h_q & ~h_active & v_active;
  assign flush    = v_fall;
  // Horizontal requests are ignored until the first frame has been armed by
  // a vertical blank, so nothing is fetched straight out of reset.
  assign line_req = v_fall | (h_fall & armed_q);

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_ACK_WAIT, S_STORE} state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic          abort_q;
  logic          kill, push, ovf, last_word;
  logic [IW-1:0] idx_q;
  logic [31:0]   row_addr_q;
  logic [31:0]   word_q;

  // An abort is owed to any fetch in flight when a flush arrives.
  assign kill      = abort_q | flush;
  assign last_word = (idx_q == IDX_LAST);

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    push      = 1'b0;
    ovf       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (line_req || pending_q) state_d = S_BUS;
        // One of the two requests starts now; a second one stays pending.
        pending_d = pending_q & line_req;
      end
      S_BUS:      state_d = S_ACK_WAIT;
      S_ACK_WAIT: if (bus.ack) state_d = kill ? S_IDLE : S_STORE;
      S_STORE: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          push    = 1'b1;
          state_d = last_word ? S_IDLE : S_BUS;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && line_req) begin
      ovf       = pending_q;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      abort_q    <= 1'b0;
      idx_q      <= '0;
      row_addr_q <= '0;
      word_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      abort_q   <= (state_d != S_IDLE) && (abort_q || (flush && state_q != S_IDLE));
      if (state_q == S_ACK_WAIT && bus.ack) word_q <= bus.dat_i;
      if (flush) begin
        row_addr_q <= fb_base;
        idx_q      <= '0;
      end else if (state_q == S_STORE && !abort_q) begin
        if (last_word) begin
          idx_q      <= '0;
          row_addr_q <= row_addr_q + LINE_STEP;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.cyc   = (state_q == S_BUS) || (state_q == S_ACK_WAIT);
  assign bus.stb   = (state_q == S_BUS);
  assign bus.we    = 1'b0;
  assign bus.sel   = 4'hf;
  assign bus.dat_o = '0;
  assign bus.adr   = row_addr_q + (32'(idx_q) << 2);

  // -------------------------------------------------------------------------
  // Show-ahead line FIFO
  // -------------------------------------------------------------------------
  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   fifo_cnt_q;
  logic               fifo_empty, fifo_full, pop_req, do_pop, do_push;
  logic [31:0]        fifo_head;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = fifo_cnt_q[FIFO_AW];
  assign do_pop     = pop_req & ~fifo_empty;
  assign do_push    = push & (~fifo_full | do_pop);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // NOTE: the storage array has no reset; the pointers and count alone
  // define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) fifo_mem[wr_ptr_q] <= word_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pixel serialiser and colour mapping
  // -------------------------------------------------------------------------
  logic                active, pix_step;
  logic [4:0]          p_q;
  logic [31:0]         shifted;
  logic [PIX_BITS-1:0] pix_val;
  logic [BPP-1:0]      grey;
  logic [3*BPP-1:0]    pix_rgb;

  assign active   = h_active & v_active;
  assign pix_step = pix_en & active;
  assign pop_req  = pix_step & (p_q == P_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || !h_active) p_q <= '0;
    else if (pix_step)      p_q <= (p_q == P_LAST) ? 5'd0 : p_q + 5'd1;
  end

  always_comb begin
    shifted = fifo_head << (p_q * PB5);
    pix_val = shifted[31 -: PIX_BITS];
    grey    = '0;
    pix_rgb = '0;
    if (PIX_BITS == 1) begin
      pix_rgb = (!fifo_empty && pix_val[0]) ? fg_color : bg_color;
    end else if (!fifo_empty) begin
      // Replicate the pixel value MSB-first across the channel width.
      for (int i = 0; i < BPP; i++) grey[BPP-1-i] = pix_val[PIX_BITS-1-(i % PIX_BITS)];
      pix_rgb = {grey, grey, grey};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      blank_n <= 1'b0;
    end else if (pix_en) begin
      blank_n              <= active;
      {red, green, blue}   <= active ? pix_rgb : '0;
    end
  end

  // Sticky underflow: a starved active pixel or a request overrun sets it;
  // setting takes priority over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      underflow <= 1'b0;
    else if ((pix_step && fifo_empty) || ovf)       underflow <= 1'b1;
    else if (underflow_clr)                         underflow <= 1'b0;
  end

endmodule

// File: tb/tb_gm_scan.sv
// ---------------------------------------------------------------------------
// tb_gm_scan : directed bench for gm_scan.
// DUT A: PIX_BITS=1, 640 pixels (20 words/line), base 0x1000.
// DUT B: PIX_BITS=4, 640 pixels (80 words/line), base 0x4000.
// Each bus has a slave that acks two cycles after the strobe cycle.
// ---------------------------------------------------------------------------
module tb_gm_scan;
  logic        clk = 1'b0;
  logic        rst, pix_en, h_act, v_act, uf_clr;
  logic [31:0] base_a, base_b;
  logic [23:0] fg, bg;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        blank_a, blank_b, uf_a, uf_b;

  int checks = 0;
  int errors = 0;

  if_wb bus_a ();
  if_wb bus_b ();

  always #5 clk = ~clk;

  gm_scan #(.BPP(8), .PIX_BITS(1), .H_PIXELS(640), .FIFO_AW(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .pix_en(pix_en), .h_active(h_act), .v_active(v_act),
    .fb_base(base_a), .fg_color(fg), .bg_color(bg), .underflow_clr(uf_clr),
    .red(r_a), .green(g_a), .blue(b_a), .blank_n(blank_a), .underflow(uf_a),
    .bus(bus_a)
  );

  gm_scan #(.BPP(8), .PIX_BITS(4), .H_PIXELS(640), .FIFO_AW(7)) dut_b (
    .clk_i(clk), .rst_i(rst), .pix_en(pix_en), .h_active(h_act), .v_active(v_act),
    .fb_base(base_b), .fg_color(fg), .bg_color(bg), .underflow_clr(uf_clr),
    .red(r_b), .green(g_b), .blue(b_b), .blank_n(blank_b), .underflow(uf_b),
    .bus(bus_b)
  );

  // ---------------- slave A: logs reads, ack gate for starvation tests -----
  logic [31:0] mem_a [64];
  logic [31:0] rd_log_a [128];
  int          rd_cnt_a = 0;
  int          a_cnt = 0;
  int          a_word = 0;
  logic        a_ack_en;

  always @(negedge clk) begin
    bus_a.ack = 1'b0;
    if (a_cnt > 0) begin
      if (a_ack_en) begin
        a_cnt--;
        if (a_cnt == 0) begin
          bus_a.ack   = 1'b1;
          bus_a.dat_i = mem_a[a_word];
        end
      end
    end else if (bus_a.cyc === 1'b1 && bus_a.stb === 1'b1) begin
      if (rd_cnt_a < 128) rd_log_a[rd_cnt_a] = bus_a.adr;
      rd_cnt_a++;
      a_word = int'((bus_a.adr - 32'h1000) >> 2) & 63;
      a_cnt  = 2;
    end
  end

  // ---------------- slave B: always acks -----------------------------------
  int          rd_cnt_b = 0;
  int          b_cnt = 0;
  logic [31:0] b_last_adr;
  logic [31:0] b_adr;

  always @(negedge clk) begin
    bus_b.ack = 1'b0;
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) begin
        bus_b.ack   = 1'b1;
        bus_b.dat_i = (b_adr == 32'h4000) ? 32'hF000_0000 : 32'h1111_1111;
      end
    end else if (bus_b.cyc === 1'b1 && bus_b.stb === 1'b1) begin
      rd_cnt_b++;
      b_adr      = bus_b.adr;
      b_last_adr = bus_b.adr;
      b_cnt      = 2;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = 32'h0;
    mem_a[0]  = 32'h8000_0001;
    mem_a[1]  = 32'h4000_0000;
    mem_a[20] = 32'hAAAA_AAAA;
    mem_a[21] = 32'h5555_5555;
    a_ack_en = 1'b1;
    rst = 1'b1; pix_en = 1'b1; h_act = 1'b0; v_act = 1'b0; uf_clr = 1'b0;
    base_a = 32'h1000; base_b = 32'h4000;
    fg = 24'hFFFFFF; bg = 24'h000000;
    tick(5);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_rgb",   {8'h0, r_a, g_a, b_a}, 32'h0);
    check("rst_blank", {31'h0, blank_a}, 32'h0);
    check("rst_uf",    {31'h0, uf_a}, 32'h0);
    check("rst_cyc",   {31'h0, bus_a.cyc}, 32'h0);

    // No fetch before the first vertical blank, even across an h_active fall
    v_act = 1'b1; tick(2);
    h_act = 1'b1; tick(10);
    check("prearm_uf",    {31'h0, uf_a}, 32'h1);
    check("prearm_blank", {31'h0, blank_a}, 32'h1);
    check("prearm_bg",    {8'h0, r_a, g_a, b_a}, 32'h0);
    h_act = 1'b0; tick(50);
    check("prearm_reads", rd_cnt_a, 0);
    uf_clr = 1'b1; tick(1); uf_clr = 1'b0; tick(1);
    check("prearm_clr", {31'h0, uf_a}, 32'h0);

    // Frame 1: prefetch line 0 during vertical blank
    v_act = 1'b0; tick(450);
    check("f1_nreads", rd_cnt_a, 20);
    for (int i = 0; i < 20; i++) check($sformatf("f1_rd%0d", i), rd_log_a[i], 32'h1000 + 32'(4 * i));
    check("b_nreads", rd_cnt_b, 80);
    check("b_last_adr", b_last_adr, 32'h413C);

    // Frame 1 line 0
    v_act = 1'b1; tick(5);
    h_act = 1'b1;
    for (int k = 0; k < 640; k++) begin
      tick(1);
      if (k < 32) check($sformatf("f1_pix%0d", k), {8'h0, r_a, g_a, b_a},
                        (k == 0 || k == 31) ? 32'hFFFFFF : 32'h0);
      if (k == 32) check("f1_pix32", {8'h0, r_a, g_a, b_a}, 32'h0);
      if (k == 33) check("f1_pix33", {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      if (k == 0)  check("b_pix0", {8'h0, r_b, g_b, b_b}, 32'hFFFFFF);
      if (k == 1)  check("b_pix1", {8'h0, r_b, g_b, b_b}, 32'h0);
      if (k == 8)  check("b_pix8", {8'h0, r_b, g_b, b_b}, 32'h111111);
    end
    h_act = 1'b0; tick(450);
    check("l1_nreads", rd_cnt_a, 40);
    check("l1_first",  rd_log_a[20], 32'h1050);
    check("l1_last",   rd_log_a[39], 32'h109C);
    check("l0_uf",     {31'h0, uf_a}, 32'h0);
    check("b_l1_nreads", rd_cnt_b, 160);

    // Frame 1 line 1, partial, then vertical blank with words left in FIFO
    h_act = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (k == 0) check("l1_pix0", {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      if (k == 1) check("l1_pix1", {8'h0, r_a, g_a, b_a}, 32'h0);
    end
    h_act = 1'b0; v_act = 1'b0; tick(450);
    check("f2_nreads", rd_cnt_a, 60);
    check("f2_first",  rd_log_a[40], 32'h1000);
    check("f2_last",   rd_log_a[59], 32'h104C);

    // Frame 2 line 0: no stale word from the flushed line
    v_act = 1'b1; tick(5);
    h_act = 1'b1;
    for (int k = 0; k < 640; k++) begin
      tick(1);
      if (k == 0)  check("f2_pix0",  {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      if (k == 1)  check("f2_pix1",  {8'h0, r_a, g_a, b_a}, 32'h0);
      if (k == 31) check("f2_pix31", {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      if (k == 32) check("f2_pix32", {8'h0, r_a, g_a, b_a}, 32'h0);
    end

    // Slave never acks line 1: starved line shows bg and sets underflow
    a_ack_en = 1'b0;
    bg = 24'h123456;
    h_act = 1'b0; tick(100);
    check("stall_nreads", rd_cnt_a, 61);
    check("stall_cyc",    {31'h0, bus_a.cyc}, 32'h1);
    check("stall_uf0",    {31'h0, uf_a}, 32'h0);
    h_act = 1'b1;
    for (int k = 0; k < 640; k++) begin
      tick(1);
      if (k == 0)   check("stall_pix0",   {8'h0, r_a, g_a, b_a}, 32'h123456);
      if (k == 300) check("stall_pix300", {8'h0, r_a, g_a, b_a}, 32'h123456);
    end
    check("stall_uf1", {31'h0, uf_a}, 32'h1);

    // Vertical blank while the fetch is stuck: abort after the late ack
    h_act = 1'b0; v_act = 1'b0; tick(5);
    check("stall_uf_hold", {31'h0, uf_a}, 32'h1);
    check("abort_noread",  rd_cnt_a, 61);
    uf_clr = 1'b1; tick(1); uf_clr = 1'b0; tick(1);
    check("stall_uf_clr", {31'h0, uf_a}, 32'h0);
    bg = 24'h000000;
    a_ack_en = 1'b1; tick(200);
    check("f3_nreads", rd_cnt_a, 81);
    check("f3_first",  rd_log_a[61], 32'h1000);
    check("f3_uf",     {31'h0, uf_a}, 32'h0);

    // Frame 3 line 0: the aborted word must not appear
    v_act = 1'b1; tick(5);
    h_act = 1'b1;
    for (int k = 0; k < 640; k++) begin
      tick(1);
      if (k == 0)  check("f3_pix0",  {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      if (k == 31) check("f3_pix31", {8'h0, r_a, g_a, b_a}, 32'hFFFFFF);
      if (k == 32) check("f3_pix32", {8'h0, r_a, g_a, b_a}, 32'h0);
    end

    // Reset during ACK_WAIT while displaying a starved line
    a_ack_en = 1'b0;
    bg = 24'h123456;
    h_act = 1'b0; tick(3);
    h_act = 1'b1; tick(3);
    check("pre_rst_cyc",   {31'h0, bus_a.cyc}, 32'h1);
    check("pre_rst_blank", {31'h0, blank_a}, 32'h1);
    check("pre_rst_uf",    {31'h0, uf_a}, 32'h1);
    rst = 1'b1; tick(1);
    check("mid_rst_cyc",   {31'h0, bus_a.cyc}, 32'h0);
    check("mid_rst_stb",   {31'h0, bus_a.stb}, 32'h0);
    check("mid_rst_rgb",   {8'h0, r_a, g_a, b_a}, 32'h0);
    check("mid_rst_blank", {31'h0, blank_a}, 32'h0);
    check("mid_rst_uf",    {31'h0, uf_a}, 32'h0);
    h_act = 1'b0; tick(1);
    rst = 1'b0; bg = 24'h000000;
    a_ack_en = 1'b1; tick(20);
    check("stray_ack_cyc",   {31'h0, bus_a.cyc}, 32'h0);
    check("stray_ack_reads", rd_cnt_a, 82);
    v_act = 1'b0; tick(150);
    check("post_rst_nreads", rd_cnt_a, 102);
    check("post_rst_first",  rd_log_a[82], 32'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gm_scan.md
GM_SCAN -- requirements
Module: gm_scan

Interface
REQ-001 Parameter BPP, default 8: bits per colour channel.
REQ-002 Parameter PIX_BITS, default 1: framebuffer bits per pixel; legal 1,2,4,8.
REQ-003 Parameter H_PIXELS, default 640: visible pixels per line; H_PIXELS*PIX_BITS SHALL be a multiple of 32; WPL = H_PIXELS*PIX_BITS/32.
REQ-004 Parameter FIFO_AW, default 5: line FIFO depth 2^FIFO_AW words; elaboration SHALL fail if 2^FIFO_AW < WPL.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  system, bus and pixel clock.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 pix_en  in  1  pixel clock enable; one pixel per asserted cycle.
REQ-009 h_active, v_active  in  1 each  timing from controller, change only on pix_en cycles.
REQ-010 fb_base  in  32  frame base byte address, word aligned.
REQ-011 fg_color, bg_color  in  3*BPP each  {r,g,b} colours for PIX_BITS=1.
REQ-012 underflow_clr  in  1  clears underflow.
REQ-013 red, green, blue  out  BPP each; blank_n  out  1; underflow  out  1 sticky.
REQ-014 bus  if_wb.master  Wishbone classic read master, 32-bit.

Function
REQ-015 Edges of h_active/v_active SHALL be detected against 1-cycle registered copies, every clk_i cycle.
REQ-016 Fetch FSM states: IDLE, BUS, ACK_WAIT, STORE.
- IDLE->BUS on line request.
- BUS->ACK_WAIT unconditionally.
- ACK_WAIT->STORE on bus.ack, capturing dat_i.
- STORE: push word; if idx != WPL-1, idx+1 -> BUS; else idx=0, row_addr += 4*WPL -> IDLE.
REQ-017 bus.cyc = BUS|ACK_WAIT; bus.stb = BUS; bus.we=0; bus.sel=4'hf; bus.dat_o=0; bus.adr = row_addr + 4*idx.
REQ-018 v_active falling edge: flush FIFO, latch row_addr=fb_base, idx=0, raise line request (prefetch line 0 during vertical blank).
REQ-019 h_active falling edge while v_active=1 SHALL raise a line request.
REQ-020 Line requests while FSM not IDLE SHALL be held in a one-deep pending flag; a second overlapping request SHALL set underflow.
REQ-021 Flush coinciding with an active fetch SHALL abort it: FSM to IDLE after any outstanding ack (ACK_WAIT holds until ack), word discarded, then prefetch begins.
REQ-022 FIFO is show-ahead; push and pop in the same cycle SHALL both take effect; flush wins over push and pop.
REQ-023 Pixel counter p (0..32/PIX_BITS-1) SHALL clear while h_active=0 and advance on pix_en with h_active&v_active.
REQ-024 Pixel value = FIFO head bits [31-p*PIX_BITS -: PIX_BITS] (MSB first); last pixel of a word SHALL pop the FIFO.
REQ-025 Colour: PIX_BITS=1 -> value ? fg_color : bg_color; else value bit-replicated to BPP on all three channels (grey).
REQ-026 Active pixel with FIFO empty: output bg_color (PIX_BITS=1) or 0, no pop, set underflow.
REQ-027 red/green/blue/blank_n SHALL be registered, updated only on pix_en cycles, latency one pix_en cycle after timing; blank_n = h_active&v_active; colour 0 when blanked.
REQ-028 underflow SHALL stay set until underflow_clr or reset; set wins over a simultaneous clear.

Reset
REQ-029 On rst_i: FSM IDLE, idx=0, row_addr=0, pending=0, FIFO empty, p=0, cyc=stb=0, red=green=blue=0, blank_n=0, underflow=0.
REQ-030 Reset mid-cycle SHALL drop cyc/stb the following cycle; later stray acks SHALL be ignored in IDLE.
REQ-031 After reset no fetch SHALL occur before the first v_active falling edge.

Verification
REQ-032 PIX_BITS=1, H_PIXELS=640, fb_base=0x1000, ack latency 2: after v_active fall -> 20 reads at 0x1000..0x104C; line 1 reads at 0x1050.
REQ-033 Word 0x80000001, fg=0xFFFFFF, bg=0x000000 -> pixel 0 and 31 white, pixels 1..30 black, pop after pixel 31.
REQ-034 PIX_BITS=4, BPP=8, word 0xF0000000 -> pixel 0 = 0xFF on each channel, pixel 1 = 0x00; WPL=80.
REQ-035 Slave never acks line 1 -> line 1 pixels bg, underflow=1 until underflow_clr pulse.
REQ-036 Assert rst_i during ACK_WAIT -> cyc=0 next cycle, all outputs at reset values, late ack ignored.
REQ-037 v_active falls with a partial line in the FIFO -> FIFO flushed, next frame line 0 data from fb_base, no stale word displayed.
